// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants and types for the CNN layer engines
// Purpose : requester indices, requester count and the read-arbiter state
//           encoding shared by the arbiter and its users.
// Ports   : none (package).
package cnn_pkg;

  localparam int NUM_REQ     = 3;
  localparam int REQ_CONV    = 0;
  localparam int REQ_MAXPOOL = 1;
  localparam int REQ_FC      = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin winner selection
// Purpose : picks the first set request bit at or after the round-robin
//           pointer, wrapping around; output is one-hot or zero.
// Ports   : i_req     - candidate request vector
//           i_rr_ptr  - index where the search starts
//           o_winner  - one-hot winner (zero when no candidate)
//           o_valid   - at least one candidate present
module rr_priority_picker #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_winner,
  output logic               o_valid
);

  int w_idx;

  // Walk from the farthest position back to the pointer so that the
  // candidate nearest the pointer is the last one written and wins.
  always_comb begin
    o_winner = '0;
    w_idx    = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_idx = (int'(i_rr_ptr) + off) % NUM_REQ;
      if (i_req[w_idx]) begin
        o_winner        = '0;
        o_winner[w_idx] = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/ram_read_arbiter.sv
// rtl/ram_read_arbiter.sv - shared RAM read-port arbiter for the layer engines
// Purpose : grants the single RAM read port to one engine at a time with
//           round-robin fairness and burst-bounded preemption, and routes
//           read data back to the engine that issued each read.
// Ports   : i_clk, i_rst   - clock, asynchronous active-high reset
//           i_req          - per-requester ownership request (level)
//           i_rd_en        - per-requester read strobe
//           i_rd_addr      - packed per-requester read addresses
//           o_gnt          - registered one-hot grant
//           o_rsp_valid    - one-hot response marker per requester
//           o_rsp_data     - RAM read data (shared)
//           o_ram_en       - RAM read enable
//           o_ram_addr     - RAM read address
//           i_ram_rdata    - RAM read data, RD_LATENCY after o_ram_en
//           o_busy         - grant held or read in flight
module ram_read_arbiter #(
  parameter int NUM_REQ    = cnn_pkg::NUM_REQ,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_rd_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_ram_en,
  output logic [ADDR_WIDTH-1:0]         o_ram_addr,
  input  logic [DATA_WIDTH-1:0]         i_ram_rdata,
  output logic                          o_busy
);

  import cnn_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [NUM_REQ-1:0]    w_gnt_nxt;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      w_rr_ptr_nxt;
  logic [CNT_W-1:0]      r_burst_cnt;
  logic [CNT_W-1:0]      w_burst_cnt_nxt;
  logic [NUM_REQ-1:0]    r_tag [RD_LATENCY];

  logic [NUM_REQ-1:0]    w_accept_tag;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_owner_addr;
  logic                  w_owner_req;
  logic                  w_others_req;
  logic                  w_burst_full;
  logic                  w_rearb;
  logic [NUM_REQ-1:0]    w_arb_req;
  logic [NUM_REQ-1:0]    w_pick;
  logic                  w_pick_valid;
  logic [PTR_W-1:0]      w_pick_ptr;
  logic                  w_tags_busy;

  // Only the owner's strobe can reach the RAM; other strobes are masked here.
  assign w_accept_tag = r_gnt & i_rd_en;
  assign w_accept     = |w_accept_tag;
  assign w_owner_req  = |(r_gnt & i_req);
  assign w_others_req = |(i_req & ~r_gnt);
  assign w_burst_full = (r_burst_cnt == CNT_W'(MAX_BURST));

  // The current owner never competes against itself, so a preempted owner
  // that keeps its request up simply waits for the pointer to come round.
  assign w_arb_req = i_req & ~r_gnt;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_req    (w_arb_req),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_pick),
    .o_valid  (w_pick_valid)
  );

  always_comb begin
    w_pick_ptr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) begin
        w_pick_ptr = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_comb begin
    w_owner_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) begin
        w_owner_addr = w_owner_addr | i_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    w_rearb         = 1'b0;

    if (w_accept && !w_burst_full) begin
      w_burst_cnt_nxt = r_burst_cnt + 1'b1;
    end

    case (r_state)
      ST_IDLE:  w_rearb = 1'b1;
      ST_OWNED: w_rearb = !w_owner_req || (w_burst_full && w_others_req);
      default:  w_rearb = 1'b0;
    endcase

    // Handover happens on the same edge that removes the old grant, so a
    // waiting requester never sees a gap cycle.
    if (w_rearb) begin
      if (w_pick_valid) begin
        w_state_nxt     = ST_OWNED;
        w_gnt_nxt       = w_pick;
        w_rr_ptr_nxt    = w_pick_ptr;
        w_burst_cnt_nxt = '0;
      end else begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      // Tags travel with the RAM latency so late data still reaches the
      // requester that issued the read, whoever owns the port by then.
      r_tag[0] <= w_accept_tag;
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  always_comb begin
    w_tags_busy = 1'b0;
    for (int s = 0; s < RD_LATENCY; s++) begin
      w_tags_busy = w_tags_busy | (|r_tag[s]);
    end
  end

  assign o_gnt       = r_gnt;
  assign o_rsp_valid = r_tag[RD_LATENCY-1];
  assign o_rsp_data  = i_ram_rdata;
  assign o_ram_en    = w_accept;
  assign o_ram_addr  = w_owner_addr;
  assign o_busy      = (|r_gnt) | w_tags_busy;

endmodule
